// File: rtl/serial_parity_checker_if.sv
// serial_parity_checker_if
//   Bundles the serial input handshake and the word-level results of the
//   framed serial parity checker.
//
//   Signals:
//     start      - single-cycle pulse that opens a frame when the checker is idle
//     bit_in     - serial payload/parity bit
//     bit_valid  - bit_in is sampled on each clock edge where this is high
//     busy       - checker is inside a frame
//     data_out   - last received payload, LSB = first bit received
//     done       - one-cycle pulse, frame complete
//     parity_err - parity mismatch for the last completed frame
//     bit_cnt    - payload bits received in the current frame
//
//   Modports:
//     master - the bit source (drives start/bit_in/bit_valid, observes results)
//     slave  - the checker itself
interface serial_parity_checker_if #(
  parameter int DATA_BITS = 8
) ();

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic [DATA_BITS-1:0] data_out;
  logic                 done;
  logic                 parity_err;
  logic [CNT_W-1:0]     bit_cnt;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, data_out, done, parity_err, bit_cnt
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, data_out, done, parity_err, bit_cnt
  );

endinterface

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
//   Framed serial receiver. After a start pulse it collects DATA_BITS payload
//   bits LSB-first, folding each into a running XOR, then takes one parity bit
//   and reports the assembled word together with a parity-error flag.
//
//   Build option:
//     ODD_PARITY_EN - when defined the frame uses odd parity (payload plus
//                     parity bit must hold an odd number of ones); otherwise
//                     even parity. Ports and timing are identical in both.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - serial_parity_checker_if.slave (start, bit_in, bit_valid in;
//            busy, data_out, done, parity_err, bit_cnt out; all outputs
//            registered)
module serial_parity_checker #(
  parameter int DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_parity_checker_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q,      state_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                 acc_q,        acc_d;
  logic [CNT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] data_out_q,   data_out_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q,       busy_d;
  logic                 done_q,       done_d;

  // Next-state and datapath logic. Everything holds by default so that gap
  // cycles (bit_valid low) and ignored inputs leave the frame untouched.
  // busy and done are decoded from the *next* state so that the registered
  // versions line up exactly with the state they describe.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    acc_d        = acc_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;

    case (state_q)
      IDLE: begin
        // bit_valid is deliberately ignored here, even on the start cycle.
        if (bus.start) begin
          state_d   = DATA;
          shreg_d   = '0;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          // Shift in from the top so the first bit ends up in bit 0.
          shreg_d   = {bus.bit_in, shreg_q[DATA_BITS-1:1]};
          acc_d     = acc_q ^ bus.bit_in;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_CNT) begin
            state_d = PAR;
          end
        end
      end
      PAR: begin
        if (bus.bit_valid) begin
          data_out_d   = shreg_q;
          parity_err_d = acc_q ^ bus.bit_in ^ ODD;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset wins over every other input and
  // silently aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      acc_q        <= 1'b0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      acc_q        <= acc_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = data_out_q;
  assign bus.parity_err = parity_err_q;
  assign bus.bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker
//   Self-checking bench for serial_parity_checker (DATA_BITS = 8). Frames are
//   described in a vector table; each frame's expected word and parity flag
//   are queued when its parity bit is driven and compared when done pulses.
//   Reset-abort is exercised by a hand-written sequence.
module tb_serial_parity_checker;

  localparam int DATA_BITS = 8;

`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         gaps;
    int         restartAt;
    bit         idleValid;
    logic [7:0] expData;
    logic       expPerrEven;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } sb_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  sb_t  sbQueue[$];

  serial_parity_checker_if #(.DATA_BITS(DATA_BITS)) bus ();

  serial_parity_checker #(.DATA_BITS(DATA_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive the inputs for one cycle, then step to just after the next edge.
  task automatic applyStimulus(input logic s, input logic v, input logic b);
    bus.start     = s;
    bus.bit_valid = v;
    bus.bit_in    = b;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending frame");
      end else begin
        sb_t exp;
        exp = sbQueue.pop_front();
        checkOutput("sb_data_out", 32'(bus.data_out), 32'(exp.data));
        checkOutput("sb_parity_err", 32'(bus.parity_err), 32'(exp.perr));
      end
    end
  end

  // One full frame: optional idle bit_valid noise, start, payload with
  // optional gaps and an optional stray start, parity, done and return to idle.
  task automatic sendFrame(input vec_t v);
    sb_t  exp;
    logic expPerr;
    expPerr = v.expPerrEven ^ ODD;
    if (v.idleValid) begin
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, v.idleValid, 1'b1);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    checkOutput("cnt_after_start", 32'(bus.bit_cnt), 32'd0);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (v.gaps) begin
        int nGap;
        nGap = int'($urandom_range(0, 2));
        for (int g = 0; g < nGap; g++) begin
          applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
          checkOutput("cnt_in_gap", 32'(bus.bit_cnt), 32'(i));
          checkOutput("busy_in_gap", 32'(bus.busy), 32'd1);
        end
      end
      applyStimulus(i == v.restartAt, 1'b1, v.data[i]);
      checkOutput("cnt_step", 32'(bus.bit_cnt), 32'(i + 1));
      checkOutput("busy_in_frame", 32'(bus.busy), 32'd1);
      checkOutput("no_early_done", 32'(bus.done), 32'd0);
    end
    exp.data = v.expData;
    exp.perr = expPerr;
    sbQueue.push_back(exp);
    applyStimulus(1'b0, 1'b1, v.par);
    checkOutput("done_latency", 32'(bus.done), 32'd1);
    checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, v.idleValid, 1'b1);
    checkOutput("done_one_cycle", 32'(bus.done), 32'd0);
    checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
    checkOutput("cnt_after_done", 32'(bus.bit_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("data_out_held", 32'(bus.data_out), 32'(v.expData));
    checkOutput("parity_err_held", 32'(bus.parity_err), 32'(expPerr));
  endtask

  // Main sequence: reset, table-driven frames, then the reset-abort case.
  initial begin
    vec_t vecs[$];
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;

    //          data   par   gaps  rstAt idleV expData expPerrEven
    vecs.push_back('{8'hA5, 1'b0, 1'b0, -1, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'hA5, 1'b1});
    vecs.push_back('{8'h03, 1'b0, 1'b0, -1, 1'b0, 8'h03, 1'b0});
    vecs.push_back('{8'h80, 1'b1, 1'b1, -1, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'h80, 1'b1, 1'b0,  3, 1'b1, 8'h80, 1'b0});
    vecs.push_back('{8'h01, 1'b0, 1'b0, -1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'h01, 1'b1, 1'b1, -1, 1'b0, 8'h01, 1'b0});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, -1, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b1});

    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
    checkOutput("rst_parity_err", 32'(bus.parity_err), 32'd0);
    checkOutput("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    foreach (vecs[n]) sendFrame(vecs[n]);

    // Reset in the middle of a frame: no done, everything back to zero.
    begin
      logic [7:0] partial;
      partial = 8'h3C;
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, partial[i]);
      checkOutput("abort_cnt_before", 32'(bus.bit_cnt), 32'd5);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_bit_cnt", 32'(bus.bit_cnt), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_data_out", 32'(bus.data_out), 32'd0);
      checkOutput("abort_parity_err", 32'(bus.parity_err), 32'd0);
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_stays_idle", 32'(bus.busy), 32'd0);
      end
    end

    sendFrame('{8'h5A, 1'b0, 1'b0, -1, 1'b0, 8'h5A, 1'b0});

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
